muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, operand width set by WIDTH.
- Sits beside the execute-stage ALU. Runs MULT/MULTU/DIV/DIVU over several cycles, and handles MTHI/MTLO in one cycle.
- Raises busy so the pipeline stalls MFHI/MFLO and any new muldiv op until the result is committed.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- op  in  3  operation code; muldiv_pkg encoding.
- a  in  WIDTH  rs operand (dividend / multiplicand / MTHI-MTLO data).
- b  in  WIDTH  rt operand (divisor / multiplier).
- flush  in  1  abort the in-flight op (squashed instruction).
- busy  out  1  high while an op is in flight.
- done  out  1  one-cycle pulse; HI/LO hold the new result that cycle.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset mid-operation aborts with no HI/LO write and overrides start/flush.
- States: IDLE → RUN → FIX → IDLE.
- busy = (state != IDLE), registered. done is registered and high only in the cycle after FIX.
- IDLE with start=1 and op ∈ {MULT, MULTU, DIV, DIVU}:
  - Latch |a| and |b| for signed ops, raw a and b for unsigned.
  - Latch the result-sign flags and the op.
  - Set counter=WIDTH and go to RUN.
- IDLE with start=1 and op=MTHI/MTLO: hi←a or lo←a at that edge. No busy, no done.
- IDLE with an undefined op: ignored.
- RUN: one radix-2 step per cycle; counter decrements; at counter==1 go to FIX.
  - Multiply: shift-add on a 2·WIDTH accumulator.
  - Divide: restoring, non-negative remainder.
- FIX:
  - Apply sign correction: product negated if the operand signs differ; quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write {hi,lo} at the edge: multiply gives hi=product[2W-1:W], lo=product[W-1:0]; divide gives lo=quotient, hi=remainder.
  - Go to IDLE.
- Latency: start in cycle 0; busy high cycles 1..WIDTH+1; done and new hi/lo visible in cycle WIDTH+2.
- start while busy: ignored, not queued.
- start in the done cycle: accepted (state is IDLE).
- Divide by zero, signed or unsigned: no iteration error. Result is lo=all ones, hi=a (the dividend), with normal latency.
- Signed overflow (most-negative ÷ −1): lo=most-negative, hi=0.
- All arithmetic is modulo 2^WIDTH per half. Product is the full 2·WIDTH bits with no truncation.
- flush in RUN or FIX: go to IDLE at the next edge; no HI/LO write; done stays 0.
- flush and start in the same IDLE cycle: flush wins and start is dropped.
- flush in IDLE with no start: no effect.
- MTHI/MTLO also blocked while busy (start ignored).
- hi/lo are stable except at the FIX edge, an MTHI/MTLO edge, or reset.

Decomposition:
- muldiv_pkg:
  - op localparams: OP_MULT=3'd0, OP_MULTU=3'd1, OP_DIV=3'd2, OP_DIVU=3'd3, OP_MTHI=3'd4, OP_MTLO=3'd5; codes 6-7 reserved.
  - State encoding: S_IDLE, S_RUN, S_FIX.
- Sub-module muldiv_step: combinational single iteration (add-shift or trial-subtract), parametrised by WIDTH.
- muldiv_unit owns the FSM, counter, sign handling and HI/LO.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done at cycle 34; hi=0xFFFFFFFE, lo=0x00000001; busy high cycles 1-33.
- MULT a=−3 (0xFFFFFFFD), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7, b=2 → lo=3, hi=1.
- DIV a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU in flight; flush at cycle 10:
  - busy=0 at cycle 11, done never pulses, hi/lo unchanged.
  - A second start at cycle 5 is ignored.
  - A repeat run with reset at cycle 20 gives hi=lo=0 and busy=0 next cycle.
- MTHI a=0xA5A5A5A5 while idle → hi=0xA5A5A5A5 next cycle, busy/done stay 0. MTLO issued while busy → ignored. Back-to-back start in the done cycle → accepted, second done WIDTH+2 cycles later.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: opcodes and FSM states shared by the multiply/divide unit
package muldiv_pkg;
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one radix-2 iteration, shift-add multiply or restoring divide
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc_in,
  input  logic [WIDTH-1:0]   opnd,
  output logic [2*WIDTH-1:0] acc_out
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic           ge;
  always_comb begin
    sum = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_in[0]}} & opnd};
    rem_sh = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
    ge = rem_sh >= {1'b0, opnd};
    // rem_sh < 2*opnd, so a successful trial always fits back in WIDTH bits
    acc_out = !is_div ? {sum, acc_in[WIDTH-1:1]}
            : ge ? {rem_sh[WIDTH-1:0] - opnd, acc_in[WIDTH-2:0], 1'b1}
            : {rem_sh[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO and single-cycle MTHI/MTLO
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod;
  logic [WIDTH-1:0]   opnd, dvd, abs_a, abs_b, quo, rmd, res_hi, res_lo;
  logic               is_div, neg_q, neg_r, dz, sgn, accept;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_in (acc),
    .opnd   (opnd),
    .acc_out(acc_step)
  );
  always_comb begin
    sgn = op == OP_MULT || op == OP_DIV;
    abs_a = sgn && a[WIDTH-1] ? -a : a;
    abs_b = sgn && b[WIDTH-1] ? -b : b;
    accept = state == S_IDLE && start && !flush;
    state_n = flush ? S_IDLE
            : state == S_IDLE ? (accept && !op[2] ? S_RUN : S_IDLE)
            : state == S_RUN ? (cnt == CNT_W'(1) ? S_FIX : S_RUN)
            : S_IDLE;
    prod = neg_q ? -acc : acc;
    quo = acc[WIDTH-1:0];
    rmd = acc[2*WIDTH-1:WIDTH];
    // divide by zero bypasses sign fix-up: all-ones quotient, dividend as remainder
    res_lo = !is_div ? prod[WIDTH-1:0] : dz ? '1 : neg_q ? -quo : quo;
    res_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : dz ? dvd : neg_r ? -rmd : rmd;
  end
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      cnt <= '0;
      acc <= '0;
      opnd <= '0;
      dvd <= '0;
      is_div <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
    end else begin
      busy <= state_n != S_IDLE;
      done <= state == S_FIX && !flush;
      if (accept && !op[2]) begin
        is_div <= op[1];
        neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r <= sgn && a[WIDTH-1];
        dz <= b == '0;
        dvd <= a;
        opnd <= op[1] ? abs_b : abs_a;
        acc <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
        cnt <= CNT_W'(WIDTH);
      end else if (state == S_RUN) begin
        acc <= acc_step;
        cnt <= cnt - CNT_W'(1);
      end
      if (accept && op == OP_MTHI) hi <= a;
      if (accept && op == OP_MTLO) lo <= a;
      if (state == S_FIX && !flush) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors against an arithmetic reference model of the muldiv unit
module tb_muldiv_unit;
  localparam int W = 32;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0;
  logic [2:0] op = 3'd0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  int checks = 0, errors = 0;
  logic [W-1:0] m_hi, m_lo, p_hi, p_lo;
  logic m_done, m_busy;
  int rem = 0;
  muldiv_unit #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx, sy;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: r = 64'(sx * sy);
      3'd1: r = {32'b0, x} * {32'b0, y};
      3'd2: r = (y == 0) ? {x, 32'hFFFFFFFF} : {32'(sx % sy), 32'(sx / sy)};
      default: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
    endcase
    return r;
  endfunction
  // reference model: a committed op becomes visible WIDTH+2 cycles after it is accepted
  always @(posedge clock) begin
    logic [63:0] r;
    if (reset) begin
      m_hi = '0; m_lo = '0; rem = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (rem > 0) begin
        if (flush) rem = 0;
        else begin
          rem--;
          if (rem == 0) begin m_hi = p_hi; m_lo = p_lo; m_done = 1'b1; end
        end
      end else if (start && !flush) begin
        if (op < 3'd4) begin
          r = ref_result(op, a, b);
          p_hi = r[63:32]; p_lo = r[31:0]; rem = W + 1;
        end else if (op == 3'd4) m_hi = a;
        else if (op == 3'd5) m_lo = a;
      end
    end
    m_busy = rem > 0;
  end
  always @(negedge clock) begin
    chk("model busy", 64'(busy), 64'(m_busy));
    chk("model done", 64'(done), 64'(m_done));
    chk("model hi", 64'(hi), 64'(m_hi));
    chk("model lo", 64'(lo), 64'(m_lo));
  end
  task automatic step();
    @(posedge clock); #1;
  endtask
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int bc);
    lat = 1; bc = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy) bc++;
      step();
      lat++;
    end
  endtask
  initial begin
    int lat, bc, nd;
    logic [W-1:0] sh, sl;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("reset hi", 64'(hi), 64'h0);
    chk("reset lo", 64'(lo), 64'h0);
    chk("reset busy", 64'(busy), 64'h0);
    chk("reset done", 64'(done), 64'h0);
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, bc);
    chk("multu latency", 64'(lat), 64'd34);
    chk("multu busy cycles", 64'(bc), 64'd33);
    chk("multu hi/lo", {hi, lo}, 64'hFFFFFFFE_00000001);
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_done(lat, bc);
    chk("back-to-back latency", 64'(lat), 64'd34);
    chk("mult hi/lo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_done(lat, bc);
    chk("div neg hi/lo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd3, 32'd7, 32'd2);
    wait_done(lat, bc);
    chk("divu hi/lo", {hi, lo}, 64'h00000001_00000003);
    issue(3'd2, 32'h12345678, 32'd0);
    wait_done(lat, bc);
    chk("div zero latency", 64'(lat), 64'd34);
    chk("div zero hi/lo", {hi, lo}, 64'h12345678_FFFFFFFF);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, bc);
    chk("div overflow hi/lo", {hi, lo}, 64'h00000000_80000000);
    issue(3'd2, 32'hFFFFFFF9, 32'd0);
    wait_done(lat, bc);
    chk("div zero neg hi/lo", {hi, lo}, 64'hFFFFFFF9_FFFFFFFF);
    step();
    issue(3'd4, 32'hA5A5A5A5, 32'd0);
    chk("mthi hi", 64'(hi), 64'h00000000_A5A5A5A5);
    chk("mthi busy", 64'(busy), 64'h0);
    chk("mthi done", 64'(done), 64'h0);
    issue(3'd1, 32'd5, 32'd6);
    issue(3'd5, 32'hDEADBEEF, 32'd0);
    wait_done(lat, bc);
    chk("mtlo while busy", {hi, lo}, 64'h00000000_0000001E);
    step();
    sh = hi; sl = lo;
    issue(3'd3, 32'd100, 32'd7);
    repeat (4) step();
    issue(3'd1, 32'd3, 32'd3);
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'h0);
    nd = 0;
    repeat (40) begin
      if (done) nd++;
      step();
    end
    chk("flush no done", 64'(nd), 64'h0);
    chk("flush hi/lo kept", {hi, lo}, {sh, sl});
    issue(3'd3, 32'd100, 32'd7);
    repeat (19) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid-op reset busy", 64'(busy), 64'h0);
    chk("mid-op reset hi/lo", {hi, lo}, 64'h0);
    flush = 1'b1;
    issue(3'd4, 32'h5A5A5A5A, 32'd0);
    flush = 1'b0;
    chk("flush beats mthi", 64'(hi), 64'h0);
    issue(3'd6, 32'h11111111, 32'd1);
    repeat (3) step();
    chk("reserved op ignored", {63'b0, busy}, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
